seq_alu: RTL and testbench

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/seq_alu_pkg.sv | 33 +++
 rtl/seq_alu_iter.sv | 106 ++++++++++
 rtl/seq_alu.sv | 194 +++++++++++++++++++
 tb/tb_seq_alu.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/seq_alu_pkg.sv
// Shared definitions for seq_alu: opcode map, FSM states, flag bit positions.
// Opcode 14 (DIV) is only active when SEQ_ALU_DIV_EN is defined.
package seq_alu_pkg;

  localparam int OP_OR   = 0;
  localparam int OP_AND  = 1;
  localparam int OP_XOR  = 2;
  localparam int OP_ADD  = 3;
  localparam int OP_SUB  = 4;
  localparam int OP_SHL  = 5;
  localparam int OP_SHR  = 6;
  localparam int OP_INC  = 7;
  localparam int OP_DEC  = 8;
  localparam int OP_ZERO = 9;
  localparam int OP_NOT  = 10;
  localparam int OP_PASS = 11;
  localparam int OP_NEG  = 12;
  localparam int OP_MUL  = 13;
  localparam int OP_DIV  = 14;

  localparam int FLAG_V = 0;
  localparam int FLAG_P = 1;
  localparam int FLAG_Z = 2;
  localparam int FLAG_N = 3;
  localparam int FLAG_C = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/seq_alu_iter.sv
// WIDTH-step iterator: shift-add multiply, plus restoring divide when SEQ_ALU_DIV_EN
// is defined. hi/lo_next expose the post-step values so the caller can latch them on done.
module seq_alu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef SEQ_ALU_DIV_EN
  input  logic             div_mode,
`endif
  input  logic [WIDTH-1:0] opnd,
  input  logic [WIDTH-1:0] lo_init,
  output logic             done,
  output logic [WIDTH-1:0] hi_next,
  output logic [WIDTH-1:0] lo_next
);

  localparam int CW = $clog2(WIDTH);

  logic             busy_q, busy_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d;
  logic [WIDTH-1:0] hi_step, lo_step, addend;
  logic [WIDTH:0]   sum;
`ifdef SEQ_ALU_DIV_EN
  logic             div_q, div_d;
  logic [WIDTH:0]   shifted, trial;
`endif

  // {hi,lo} is the product register for MUL and {remainder,quotient} for DIV.
  always_comb begin
    addend  = lo_q[0] ? opnd_q : '0;
    sum     = {1'b0, hi_q} + {1'b0, addend};
    hi_step = sum[WIDTH:1];
    lo_step = {sum[0], lo_q[WIDTH-1:1]};
`ifdef SEQ_ALU_DIV_EN
    shifted = {hi_q, lo_q[WIDTH-1]};
    trial   = shifted - {1'b0, opnd_q};
    if (div_q) begin
      if (!trial[WIDTH]) begin
        hi_step = trial[WIDTH-1:0];
        lo_step = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        hi_step = shifted[WIDTH-1:0];
        lo_step = {lo_q[WIDTH-2:0], 1'b0};
      end
    end
`endif
  end

  assign done    = busy_q && (cnt_q == CW'(WIDTH - 1));
  assign hi_next = hi_step;
  assign lo_next = lo_step;

  // NOTE: every comb output is given a default first so no latch is inferred.
  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    opnd_d = opnd_q;
`ifdef SEQ_ALU_DIV_EN
    div_d  = div_q;
`endif
    if (start) begin
      busy_d = 1'b1;
      cnt_d  = '0;
      hi_d   = '0;
      lo_d   = lo_init;
      opnd_d = opnd;
`ifdef SEQ_ALU_DIV_EN
      div_d  = div_mode;
`endif
    end else if (busy_q) begin
      hi_d  = hi_step;
      lo_d  = lo_step;
      cnt_d = done ? '0 : cnt_q + 1'b1;
      if (done) busy_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments; every flop resets asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      opnd_q <= '0;
`ifdef SEQ_ALU_DIV_EN
      div_q  <= 1'b0;
`endif
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      opnd_q <= opnd_d;
`ifdef SEQ_ALU_DIV_EN
      div_q  <= div_d;
`endif
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: IDLE/BUSY/DONE handshake FSM, single-cycle datapath and flag logic.
// Define SEQ_ALU_DIV_EN to enable opcode 14 (unsigned divide) in the iterator.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OPW   = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OPW-1:0]   opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       flags
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [4:0]       flags_q, flags_d;
  logic             accept, op_is_mul, op_is_div, is_iter;
  logic [WIDTH-1:0] sc_res, it_opnd, it_lo_init, it_hi, it_lo, it_res;
  logic             sc_c, sc_v, it_c, it_v, it_done;
  logic [WIDTH:0]   add_full, sub_full, dec_full;
  logic [WIDTH-1:0] inc_res, neg_res;
`ifdef SEQ_ALU_DIV_EN
  logic             div_q, div_d, dz_q, dz_d;
`endif

  function automatic logic [4:0] pack_flags(input logic [WIDTH-1:0] r, input logic c, input logic v);
    pack_flags         = '0;
    pack_flags[FLAG_C] = c;
    pack_flags[FLAG_N] = r[WIDTH-1];
    pack_flags[FLAG_Z] = (r == '0);
    pack_flags[FLAG_P] = ~^r;
    pack_flags[FLAG_V] = v;
  endfunction

  assign accept    = in_valid && in_ready;
  assign op_is_mul = (opcode == OPW'(OP_MUL));
`ifdef SEQ_ALU_DIV_EN
  assign op_is_div = (opcode == OPW'(OP_DIV));
`else
  assign op_is_div = 1'b0;
`endif
  assign is_iter   = op_is_mul || op_is_div;

  assign add_full = {1'b0, a} + {1'b0, b};
  assign sub_full = {1'b0, a} + {1'b0, ~b} + 1'b1;
  assign dec_full = {1'b0, a} + {1'b0, ~WIDTH'(1)} + 1'b1;
  assign inc_res  = a + 1'b1;
  assign neg_res  = ~a + 1'b1;

  always_comb begin
    sc_res = '0;
    sc_c   = 1'b0;
    sc_v   = 1'b0;
    case (opcode)
      OPW'(OP_OR):   sc_res = a | b;
      OPW'(OP_AND):  sc_res = a & b;
      OPW'(OP_XOR):  sc_res = a ^ b;
      OPW'(OP_ADD): begin
        sc_res = add_full[WIDTH-1:0];
        sc_c   = add_full[WIDTH];
        sc_v   = (a[WIDTH-1] == b[WIDTH-1]) && (sc_res[WIDTH-1] != a[WIDTH-1]);
      end
      OPW'(OP_SUB): begin
        sc_res = sub_full[WIDTH-1:0];
        sc_c   = sub_full[WIDTH];
        sc_v   = (a[WIDTH-1] != b[WIDTH-1]) && (sc_res[WIDTH-1] != a[WIDTH-1]);
      end
      OPW'(OP_SHL): begin
        sc_res = {a[WIDTH-2:0], 1'b0};
        sc_c   = a[WIDTH-1];
      end
      OPW'(OP_SHR):  sc_res = {1'b0, a[WIDTH-1:1]};
      OPW'(OP_INC): begin
        sc_res = inc_res;
        sc_v   = !a[WIDTH-1] && inc_res[WIDTH-1];
      end
      OPW'(OP_DEC): begin
        sc_res = dec_full[WIDTH-1:0];
        sc_c   = dec_full[WIDTH];
        sc_v   = a[WIDTH-1] && !dec_full[WIDTH-1];
      end
      OPW'(OP_NOT):  sc_res = ~a;
      OPW'(OP_PASS): sc_res = a;
      OPW'(OP_NEG): begin
        sc_res = neg_res;
        sc_v   = a[WIDTH-1] && neg_res[WIDTH-1];
      end
      default:       sc_res = '0;
    endcase
  end

  // MUL takes the multiplicand as opnd; DIV takes the divisor as opnd and the dividend in lo.
  always_comb begin
    it_opnd    = a;
    it_lo_init = b;
    if (op_is_div) begin
      it_opnd    = b;
      it_lo_init = a;
    end
  end

  seq_alu_iter #(.WIDTH(WIDTH)) u_iter (
    .clk      (clk),
    .rst      (rst),
    .start    (accept && is_iter),
`ifdef SEQ_ALU_DIV_EN
    .div_mode (op_is_div),
`endif
    .opnd     (it_opnd),
    .lo_init  (it_lo_init),
    .done     (it_done),
    .hi_next  (it_hi),
    .lo_next  (it_lo)
  );

  always_comb begin
    it_res = it_lo;
    it_c   = |it_hi;
    it_v   = 1'b0;
`ifdef SEQ_ALU_DIV_EN
    if (div_q && dz_q) begin
      it_res = '1;
      it_v   = 1'b1;
    end
`endif
  end

  always_comb begin
    result_d = result_q;
    flags_d  = flags_q;
`ifdef SEQ_ALU_DIV_EN
    div_d    = div_q;
    dz_d     = dz_q;
    if (accept) begin
      div_d = op_is_div;
      dz_d  = (b == '0);
    end
`endif
    if (accept && !is_iter) begin
      result_d = sc_res;
      flags_d  = pack_flags(sc_res, sc_c, sc_v);
    end else if (it_done) begin
      result_d = it_res;
      flags_d  = pack_flags(it_res, it_c, it_v);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = is_iter ? ST_BUSY : ST_DONE;
      ST_BUSY: if (it_done) state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      flags_q  <= '0;
`ifdef SEQ_ALU_DIV_EN
      div_q    <= 1'b0;
      dz_q     <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      flags_q  <= flags_d;
`ifdef SEQ_ALU_DIV_EN
      div_q    <= div_d;
      dz_q     <= dz_d;
`endif
    end
  end

  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
  end

  assign result = result_q;
  assign flags  = flags_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu (WIDTH=32); DIV vectors follow SEQ_ALU_DIV_EN.
module tb_seq_alu;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [6:0]  opcode = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic [4:0]  flags;

  int checks = 0;
  int errors = 0;

  seq_alu #(.WIDTH(32), .OPW(7)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .opcode    (opcode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Issues one request, then waits at falling edges until out_valid; lat counts cycles after accept.
  task automatic issue(input logic [6:0] op, input logic [31:0] va, input logic [31:0] vb,
                       output int lat, output logic ready_low);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    opcode   = op;
    a        = va;
    b        = vb;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    a         = 32'hDEAD_BEEF;
    b         = 32'h1234_5678;
    opcode    = 7'd3;
    lat       = 0;
    ready_low = 1'b1;
    do begin
      @(negedge clk);
      lat++;
      if (!out_valid && in_ready) ready_low = 1'b0;
    end while (!out_valid && lat < 100);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check("idle_in_ready", in_ready, 1);
    check("idle_out_valid", out_valid, 0);
  endtask

  typedef struct {
    string       tag;
    logic [6:0]  op;
    logic [31:0] va;
    logic [31:0] vb;
    logic [31:0] res;
    logic [4:0]  fl;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat;
    logic rl;
    logic saw;

    // Asynchronous reset is observed before any clock edge.
    #1 rst = 1'b1;
    #2;
    check("rst_result", result, 0);
    check("rst_flags", flags, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    vecs.push_back('{"add_ovf",  7'd3,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 5'b01001});
    vecs.push_back('{"sub_eq",   7'd4,  32'd5,         32'd5,         32'h0000_0000, 5'b10110});
    // 0xFFFFFFFE has 31 ones, so parity (even-ones) is 0.
    vecs.push_back('{"sub_neg",  7'd4,  32'd3,         32'd5,         32'hFFFF_FFFE, 5'b01000});
    vecs.push_back('{"add_wrap", 7'd3,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 5'b10110});
    vecs.push_back('{"or",       7'd0,  32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 5'b00010});
    vecs.push_back('{"and",      7'd1,  32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00, 5'b00010});
    vecs.push_back('{"xor",      7'd2,  32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_FF00, 5'b00010});
    vecs.push_back('{"shl",      7'd5,  32'h8000_0001, 32'h0,         32'h0000_0002, 5'b10000});
    vecs.push_back('{"shr",      7'd6,  32'h8000_0001, 32'h0,         32'h4000_0000, 5'b00000});
    vecs.push_back('{"inc_ovf",  7'd7,  32'h7FFF_FFFF, 32'h0,         32'h8000_0000, 5'b01001});
    vecs.push_back('{"dec_0",    7'd8,  32'h0000_0000, 32'h0,         32'hFFFF_FFFF, 5'b01010});
    vecs.push_back('{"dec_1",    7'd8,  32'h0000_0001, 32'h0,         32'h0000_0000, 5'b10110});
    vecs.push_back('{"zero",     7'd9,  32'h1234_5678, 32'h0,         32'h0000_0000, 5'b00110});
    vecs.push_back('{"not",      7'd10, 32'h0000_0000, 32'h0,         32'hFFFF_FFFF, 5'b01010});
    vecs.push_back('{"pass",     7'd11, 32'h0000_0003, 32'h0,         32'h0000_0003, 5'b00010});
    vecs.push_back('{"neg_min",  7'd12, 32'h8000_0000, 32'h0,         32'h8000_0000, 5'b01001});
    vecs.push_back('{"bad_op",   7'h7F, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 5'b00110});
`ifndef SEQ_ALU_DIV_EN
    vecs.push_back('{"div_off",  7'd14, 32'd100,       32'd7,         32'h0000_0000, 5'b00110});
`endif

    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].va, vecs[i].vb, lat, rl);
      check({vecs[i].tag, "_lat"}, lat, 1);
      check({vecs[i].tag, "_res"}, result, vecs[i].res);
      check({vecs[i].tag, "_flags"}, flags, vecs[i].fl);
      handshake();
    end

    // Multiplies: 33-cycle latency, in_ready low throughout.
    issue(7'd13, 32'h0001_0000, 32'h0001_0000, lat, rl);
    check("mul_hi_lat", lat, 33);
    check("mul_hi_busy", rl, 1);
    check("mul_hi_res", result, 32'h0000_0000);
    check("mul_hi_flags", flags, 5'b10110);
    handshake();
    issue(7'd13, 32'd1234, 32'd5678, lat, rl);
    check("mul_small_res", result, 32'h006A_E9BC);
    check("mul_small_flags", flags, 5'b00010);
    handshake();
    issue(7'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, rl);
    check("mul_max_res", result, 32'h0000_0001);
    check("mul_max_flags", flags, 5'b10000);
    handshake();

`ifdef SEQ_ALU_DIV_EN
    issue(7'd14, 32'd100, 32'd7, lat, rl);
    check("div_lat", lat, 33);
    check("div_res", result, 32'd14);
    check("div_flags", flags, 5'b10000);
    handshake();
    issue(7'd14, 32'd9, 32'd0, lat, rl);
    check("div0_res", result, 32'hFFFF_FFFF);
    check("div0_ovf", flags[0], 1);
    handshake();
`endif

    // Back-pressure: outputs hold and a concurrent request is ignored.
    issue(7'd3, 32'd2, 32'd3, lat, rl);
    for (int i = 0; i < 3; i++) begin
      opcode   = 7'd3;
      a        = 32'd100;
      b        = 32'd100;
      in_valid = 1'b1;
      @(negedge clk);
      check("hold_res", result, 32'd5);
      check("hold_flags", flags, 5'b00010);
      check("hold_in_ready", in_ready, 0);
      check("hold_out_valid", out_valid, 1);
    end
    in_valid = 1'b0;
    handshake();
    @(negedge clk);
    check("hold_no_replay", out_valid, 0);
    check("hold_res_kept", result, 32'd5);

    // Reset 10 cycles into a multiply.
    @(negedge clk);
    opcode   = 7'd13;
    a        = 32'd3;
    b        = 32'd4;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_result", result, 0);
    check("midrst_flags", flags, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    saw = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) saw = 1'b1;
    end
    check("midrst_no_out_valid", saw, 0);
    issue(7'd3, 32'd1, 32'd1, lat, rl);
    check("post_rst_lat", lat, 1);
    check("post_rst_res", result, 32'd2);
    check("post_rst_flags", flags, 5'b00000);
    handshake();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
